brake_actuator: RTL and testbench

- Receiving end of the vehicle brake command: consumes the single-bit `vehicle_break` request and drives the physical brake actuator.
- Synchronises and debounces the request, then runs a ramp/hold/release state machine on a brake-force value.
- Generates the PWM drive, brake-light and braking-status outputs.
- Sits between the ADAS/driver decision logic and the brake power stage.

---
 rtl/brake_actuator_if.sv | 27 ++
 rtl/brake_actuator.sv | 163 ++++++++++++++++
 tb/tb_brake_actuator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/brake_actuator_if.sv
// Signal bundle between the brake decision logic (master) and the brake
// actuator (slave): the raw brake request and the actuator-side outputs.
interface brake_actuator_if #(
  parameter int FORCE_WIDTH = 8
);
  logic                   vehicle_break;
  logic [FORCE_WIDTH-1:0] brake_force;
  logic                   pwm_out;
  logic                   brake_light;
  logic                   braking;

  modport master (
    output vehicle_break,
    input  brake_force,
    input  pwm_out,
    input  brake_light,
    input  braking
  );

  modport slave (
    input  vehicle_break,
    output brake_force,
    output pwm_out,
    output brake_light,
    output braking
  );
endinterface

// File: rtl/brake_actuator.sv
// Brake actuator: synchronises and debounces the brake request, ramps the
// commanded force up/down through a hold phase, and drives the PWM stage,
// brake light and braking status.
module brake_actuator #(
  parameter int FORCE_WIDTH     = 8,
  parameter int RAMP_STEP       = 16,
  parameter int MIN_HOLD_CYCLES = 1000,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  brake_actuator_if.slave   bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);

  localparam logic [FORCE_WIDTH-1:0] MAX_F  = {FORCE_WIDTH{1'b1}};
  localparam logic [FORCE_WIDTH-1:0] STEP_F = FORCE_WIDTH'(RAMP_STEP);
  localparam logic [DEB_W-1:0]       DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]      HOLD_MAX    = HOLD_W'(MIN_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]      HOLD_THRESH = HOLD_W'(MIN_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN
  } state_t;

  logic [1:0]             sync_q, sync_d;
  logic                   req_filt_q, req_filt_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  state_t                 state_q, state_d;
  logic [FORCE_WIDTH-1:0] force_q, force_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [FORCE_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                   pwm_q, pwm_d;

  logic                   req_sync;
  logic [FORCE_WIDTH:0]   force_sum;
  logic [FORCE_WIDTH:0]   force_diff;
  logic                   up_sat;
  logic                   down_zero;
  logic [FORCE_WIDTH-1:0] force_up;
  logic [FORCE_WIDTH-1:0] force_down;

  assign req_sync = sync_q[1];

  // Two-flop synchroniser followed by a persistence filter on the request.
  always_comb begin
    sync_d     = {sync_q[0], bus.vehicle_break};
    req_filt_d = req_filt_q;
    deb_cnt_d  = '0;
    if (req_sync != req_filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        req_filt_d = req_sync;
        deb_cnt_d  = '0;
      end else begin
        deb_cnt_d  = deb_cnt_q + 1'b1;
      end
    end
  end

  // Saturating force step in both directions using a one-bit-wider result.
  always_comb begin
    force_sum  = {1'b0, force_q} + {1'b0, STEP_F};
    force_diff = {1'b0, force_q} - {1'b0, STEP_F};
    up_sat     = (force_sum >= {1'b0, MAX_F});
    down_zero  = force_diff[FORCE_WIDTH] || (force_diff == '0);
    force_up   = up_sat ? MAX_F : force_sum[FORCE_WIDTH-1:0];
    force_down = down_zero ? '0 : force_diff[FORCE_WIDTH-1:0];
  end

  // Ramp/hold/release sequencing; a re-request while releasing wins over
  // reaching zero and continues upward from the present force.
  always_comb begin
    state_d    = state_q;
    force_d    = force_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        force_d = '0;
        if (req_filt_q) begin
          state_d = RAMP_UP;
          force_d = STEP_F;
        end
      end
      RAMP_UP: begin
        force_d = force_up;
        if (up_sat) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        force_d = MAX_F;
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if ((hold_cnt_q >= HOLD_THRESH) && !req_filt_q) begin
          state_d = RAMP_DOWN;
          force_d = MAX_F - STEP_F;
        end
      end
      RAMP_DOWN: begin
        if (req_filt_q) begin
          force_d = force_up;
          if (up_sat) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d    = RAMP_UP;
          end
        end else begin
          force_d = force_down;
          if (down_zero) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        force_d = '0;
      end
    endcase
  end

  // Free-running PWM counter compared against the force, output registered.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_d     = (pwm_cnt_q < force_q);
  end

  // State registers; reset returns everything to released immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      req_filt_q <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      force_q    <= '0;
      hold_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      req_filt_q <= req_filt_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      force_q    <= force_d;
      hold_cnt_q <= hold_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign bus.brake_force = force_q;
  assign bus.pwm_out     = pwm_q;
  assign bus.brake_light = (force_q != '0);
  assign bus.braking     = (state_q == RAMP_UP) || (state_q == HOLD);

endmodule

// File: tb/tb_brake_actuator.sv
// Directed bench for brake_actuator at default parameters: reset, glitch
// rejection, full brake cycle, re-request during release, PWM duty and
// asynchronous reset while holding.
module tb_brake_actuator;

  logic clock;
  logic reset_n;
  int   testsRun;
  int   testsFailed;

  brake_actuator_if #(.FORCE_WIDTH(8)) bus ();

  brake_actuator #(
    .FORCE_WIDTH     (8),
    .RAMP_STEP       (16),
    .MIN_HOLD_CYCLES (1000),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: count it, report on mismatch
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Hold the request at a level for some clocks, counting any output activity
  task automatic applyStimulus(input logic brk, input int cycles, output int activity);
    activity = 0;
    bus.vehicle_break = brk;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.brake_force != 8'd0 || bus.pwm_out || bus.brake_light || bus.braking)
        activity++;
    end
  endtask

  // Expected force after edge e, counting edges from request assertion
  function automatic int expForce(input int e, input bit reReq);
    int v;
    if (e < 7) return 0;
    if (e <= 21) return 16 * (e - 6);
    if (e <= 1021) return 255;
    if (!reReq) begin
      v = 255 - 16 * (e - 1021);
      return (v < 0) ? 0 : v;
    end
    if (e <= 1035) return 255 - 16 * (e - 1021);
    if (e <= 1048) return 47 + 16 * (e - 1036);
    return 255;
  endfunction

  function automatic int expBraking(input int e, input bit reReq);
    if (e >= 7 && e <= 1021) return 1;
    if (reReq && e >= 1036) return 1;
    return 0;
  endfunction

  // Request asserted for 20 clocks; optional re-request once force is 127
  task automatic runCycle(input bit reReq, input int lastEdge);
    int holdEdges;
    int pwmHigh;
    int ef;
    holdEdges = 0;
    pwmHigh   = 0;
    bus.vehicle_break = 1'b1;
    for (int e = 1; e <= lastEdge; e++) begin
      @(posedge clock);
      @(negedge clock);
      ef = expForce(e, reReq);
      checkOutput($sformatf("force_e%0d", e), int'(bus.brake_force), ef);
      checkOutput($sformatf("light_e%0d", e), int'(bus.brake_light), (ef != 0) ? 1 : 0);
      checkOutput($sformatf("braking_e%0d", e), int'(bus.braking), expBraking(e, reReq));
      if (bus.brake_force == 8'd255) holdEdges++;
      if (e >= 101 && e <= 612 && bus.pwm_out) pwmHigh++;
      if (e == 20) bus.vehicle_break = 1'b0;
      if (reReq && e == 1029) bus.vehicle_break = 1'b1;
    end
    if (!reReq && lastEdge >= 1040) begin
      checkOutput("hold_edges", holdEdges, 1000);
      checkOutput("pwm_high_of_512", pwmHigh, 510);
    end
  endtask

  initial begin
    int act;
    int act2;
    testsRun    = 0;
    testsFailed = 0;
    bus.vehicle_break = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset held for 3 clocks, outputs must be quiet
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_force", int'(bus.brake_force), 0);
    checkOutput("rst_pwm", int'(bus.pwm_out), 0);
    checkOutput("rst_light", int'(bus.brake_light), 0);
    checkOutput("rst_braking", int'(bus.braking), 0);
    reset_n = 1'b1;

    // Idle after reset
    applyStimulus(1'b0, 50, act);
    checkOutput("idle_activity", act, 0);

    // 3-clock glitch must be rejected
    applyStimulus(1'b1, 3, act);
    applyStimulus(1'b0, 15, act2);
    checkOutput("glitch_activity", act + act2, 0);

    // Full cycle to release and back to idle
    runCycle(1'b0, 1045);
    applyStimulus(1'b0, 5, act);
    checkOutput("after_cycle_idle", act, 0);

    // Re-request during release at force 127
    runCycle(1'b1, 1060);

    // Asynchronous reset while holding
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_force", int'(bus.brake_force), 0);
    checkOutput("async_pwm", int'(bus.pwm_out), 0);
    checkOutput("async_light", int'(bus.brake_light), 0);
    checkOutput("async_braking", int'(bus.braking), 0);
    @(negedge clock);
    bus.vehicle_break = 1'b0;
    reset_n = 1'b1;
    applyStimulus(1'b0, 10, act);
    checkOutput("post_reset_idle", act, 0);

    // Fresh request after reset starts from IDLE
    runCycle(1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
